// File: rtl/mem_pkg.sv
// Shared state encodings and constants for the single-port memory arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RECOVER = 2'd2
  } state_e;

  localparam logic [1:0] ST_TIMEOUT = 2'b11;
  localparam logic       OP_READ    = 1'b0;
  localparam logic       OP_WRITE   = 1'b1;

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module mem_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     winner,
  output logic               valid
);

  logic [IDW:0]   sum_s;
  logic [IDW-1:0] cand_s;

  // Scan from the farthest candidate down so the one nearest ptr is written last and wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum_s  = {1'b0, ptr} + (IDW+1)'(k);
      cand_s = (sum_s >= (IDW+1)'(NUM_REQ)) ? IDW'(sum_s - (IDW+1)'(NUM_REQ))
                                            : sum_s[IDW-1:0];
      winner = req[cand_s] ? cand_s : winner;
      valid  = valid | req[cand_s];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one en/ready memory between NUM_REQ requesters,
// with a watchdog bounding both the ready wait and the reset-recovery wait.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_op,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             done,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rstatus,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           err,
  output logic                           mem_en,
  output logic                           mem_op,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_datain,
  output logic                           mem_reset,
  input  logic [DATA_WIDTH-1:0]          mem_dataout,
  input  logic [1:0]                     mem_status,
  input  logic                           mem_ready
);

  localparam int               IDW     = $clog2(NUM_REQ);
  localparam int               WDW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WDW-1:0]   WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0]   ID_LAST = IDW'(NUM_REQ - 1);

  state_e                  state_q, state_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [WDW-1:0]          wd_q, wd_d;
  logic [IDW-1:0]          grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rstatus_q, rstatus_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_op_q, mem_op_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_datain_q, mem_datain_d;
  logic                    mem_reset_q, mem_reset_d;

  logic [IDW-1:0]          winner_s;
  logic                    valid_s;
  logic [ADDR_WIDTH-1:0]   addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  mem_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner_s),
    .valid  (valid_s)
  );

  // Next-state and registered-output logic for the handshake sequencer.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    wd_d         = wd_q;
    grant_id_d   = grant_id_q;
    done_d       = '0;
    rdata_d      = rdata_q;
    rstatus_d    = rstatus_q;
    err_d        = err_q;
    mem_en_d     = mem_en_q;
    mem_op_d     = mem_op_q;
    mem_addr_d   = mem_addr_q;
    mem_datain_d = mem_datain_q;
    mem_reset_d  = mem_reset_q;
    case (state_q)
      IDLE: begin
        if (valid_s) begin
          mem_en_d     = 1'b1;
          mem_op_d     = req_op[winner_s];
          mem_addr_d   = addr_a[winner_s];
          mem_datain_d = wdata_a[winner_s];
          grant_id_d   = winner_s;
          ptr_d        = (winner_s == ID_LAST) ? '0 : winner_s + IDW'(1);
          wd_d         = '0;
          state_d      = WAIT;
        end else begin
          mem_en_d     = 1'b0;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          rdata_d     = mem_dataout;
          rstatus_d   = mem_status;
          done_d      = NUM_REQ'(1) << grant_id_q;
          mem_en_d    = 1'b0;
          mem_reset_d = 1'b1;
          wd_d        = '0;
          state_d     = RECOVER;
        end else if (wd_q == WD_LAST) begin
          // Abort still pulses done so the requester is never left waiting.
          rdata_d     = '0;
          rstatus_d   = ST_TIMEOUT;
          done_d      = NUM_REQ'(1) << grant_id_q;
          err_d       = 1'b1;
          mem_en_d    = 1'b0;
          mem_reset_d = 1'b1;
          wd_d        = '0;
          state_d     = RECOVER;
        end else begin
          wd_d        = wd_q + WDW'(1);
        end
      end
      RECOVER: begin
        if (!mem_ready) begin
          mem_reset_d = 1'b0;
          wd_d        = '0;
          state_d     = IDLE;
        end else if (wd_q == WD_LAST) begin
          err_d       = 1'b1;
          mem_reset_d = 1'b0;
          wd_d        = '0;
          state_d     = IDLE;
        end else begin
          wd_d        = wd_q + WDW'(1);
        end
      end
      default: begin
        mem_en_d    = 1'b0;
        mem_reset_d = 1'b0;
        wd_d        = '0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight transaction silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      wd_q         <= '0;
      grant_id_q   <= '0;
      done_q       <= '0;
      rdata_q      <= '0;
      rstatus_q    <= 2'b00;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_op_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_datain_q <= '0;
      mem_reset_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wd_q         <= wd_d;
      grant_id_q   <= grant_id_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      rstatus_q    <= rstatus_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      mem_en_q     <= mem_en_d;
      mem_op_q     <= mem_op_d;
      mem_addr_q   <= mem_addr_d;
      mem_datain_q <= mem_datain_d;
      mem_reset_q  <= mem_reset_d;
    end
  end

  assign done       = done_q;
  assign rdata      = rdata_q;
  assign rstatus    = rstatus_q;
  assign grant_id   = grant_id_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign mem_en     = mem_en_q;
  assign mem_op     = mem_op_q;
  assign mem_addr   = mem_addr_q;
  assign mem_datain = mem_datain_q;
  assign mem_reset  = mem_reset_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus hand-written
// sequences for rotation, WAIT/RECOVER timeouts and reset during a transaction.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 8;

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic [NR-1:0]    req       = '0;
  logic [NR-1:0]    req_op    = '0;
  logic [NR*AW-1:0] req_addr  = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    done;
  logic [DW-1:0]    rdata;
  logic [1:0]       rstatus;
  logic [1:0]       grant_id;
  logic             busy, err, mem_en, mem_op, mem_reset;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_datain;
  logic [DW-1:0]    mem_dataout = '0;
  logic [1:0]       mem_status  = 2'b00;
  logic             mem_ready   = 1'b0;

  int   checks = 0;
  int   errors = 0;
  logic hang   = 1'b0;
  logic stuck  = 1'b0;
  logic [DW-1:0] mem_arr [256];
  int   en_cnt = 0;

  typedef struct {
    logic [3:0] req;
    logic       op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [1:0] gid;
    logic [7:0] rdata;
    logic [1:0] rstatus;
  } vec_t;
  vec_t vecs [7];

  mem_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .rdata(rdata), .rstatus(rstatus),
    .grant_id(grant_id), .busy(busy), .err(err), .mem_en(mem_en), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_reset(mem_reset),
    .mem_dataout(mem_dataout), .mem_status(mem_status), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: ready on the 3rd cycle of en, drops one cycle after mem_reset.
  always @(negedge clk) begin
    if (!reset) begin
      mem_ready = 1'b0;
      en_cnt    = 0;
    end else if (stuck) begin
      mem_ready   = 1'b1;
      mem_dataout = 8'h3C;
      mem_status  = 2'b00;
    end else if (mem_reset) begin
      mem_ready = 1'b0;
      en_cnt    = 0;
    end else if (mem_en && !hang) begin
      en_cnt++;
      if (en_cnt == 3) begin
        mem_ready = 1'b1;
        if (mem_op == OP_WRITE) begin
          mem_arr[mem_addr] = mem_datain;
          mem_dataout       = 8'hA5;
          mem_status        = 2'b01;
        end else if (mem_op == OP_READ) begin
          mem_dataout = mem_arr[mem_addr];
          mem_status  = 2'b10;
        end
      end
    end else begin
      en_cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_fields(input int i, input logic op, input logic [7:0] a, input logic [7:0] d);
    req_op[i]          = op;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_en(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(output int n, output logic ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== '0) begin
        ok = 1'b1;
        n  = i + 1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic ok;
    int   n;
    set_fields(int'(v.gid), v.op, v.addr, v.wdata);
    req = v.req;
    wait_en(ok);
    check("grant_seen", {31'd0, ok}, 32'd1);
    check("mem_addr", {24'd0, mem_addr}, {24'd0, v.addr});
    check("mem_datain", {24'd0, mem_datain}, {24'd0, v.wdata});
    check("mem_op", {31'd0, mem_op}, {31'd0, v.op});
    check("grant_id", {30'd0, grant_id}, {30'd0, v.gid});
    check("busy_wait", {31'd0, busy}, 32'd1);
    wait_done(n, ok);
    check("done_seen", {31'd0, ok}, 32'd1);
    req = '0;
    check("done_vec", {28'd0, done}, {28'd0, 4'b0001 << v.gid});
    check("rdata", {24'd0, rdata}, {24'd0, v.rdata});
    check("rstatus", {30'd0, rstatus}, {30'd0, v.rstatus});
    check("mem_en_off", {31'd0, mem_en}, 32'd0);
    check("mem_reset_on", {31'd0, mem_reset}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {28'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("mem_reset_off", {31'd0, mem_reset}, 32'd0);
  endtask

  initial begin
    logic ok;
    int   n;
    int   exp_q [$];

    for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
    vecs[0] = '{4'b0001, 1'b1, 8'h08, 8'hF0, 2'd0, 8'hA5, 2'b01};
    vecs[1] = '{4'b0010, 1'b0, 8'h08, 8'h00, 2'd1, 8'hF0, 2'b10};
    vecs[2] = '{4'b0100, 1'b1, 8'h3C, 8'h5A, 2'd2, 8'hA5, 2'b01};
    vecs[3] = '{4'b1000, 1'b0, 8'h3C, 8'h00, 2'd3, 8'h5A, 2'b10};
    vecs[4] = '{4'b0001, 1'b0, 8'h77, 8'h00, 2'd0, 8'h00, 2'b10};
    vecs[5] = '{4'b0010, 1'b1, 8'h77, 8'h81, 2'd1, 8'hA5, 2'b01};
    vecs[6] = '{4'b1000, 1'b0, 8'h77, 8'h00, 2'd3, 8'h81, 2'b10};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_done", {28'd0, done}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_rstatus", {30'd0, rstatus}, 32'd0);
    check("rst_grant", {30'd0, grant_id}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_reset", {31'd0, mem_reset}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    reset = 1'b1;

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // Rotation with all requesters pending, from a fresh pointer
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NR; i++) set_fields(i, 1'b0, 8'h10 + 8'(i), 8'h00);
    req = 4'b1111;
    exp_q = '{0, 1, 2, 3, 0, 3};
    for (int k = 0; k < 6; k++) begin
      wait_done(n, ok);
      check("rr_done_seen", {31'd0, ok}, 32'd1);
      check("rr_order", {28'd0, done}, 32'd1 << exp_q[k]);
      check("rr_grant", {30'd0, grant_id}, exp_q[k]);
      req[exp_q[k]] = 1'b0;
      if (k == 3) req = 4'b1001;
    end
    @(negedge clk);
    check("rr_idle", {31'd0, busy}, 32'd0);

    // Memory never answers: abort after TO WAIT cycles
    hang = 1'b1;
    set_fields(2, 1'b1, 8'h20, 8'h11);
    req = 4'b0100;
    check("err_before", {31'd0, err}, 32'd0);
    wait_en(ok);
    check("to_grant_seen", {31'd0, ok}, 32'd1);
    check("to_grant", {30'd0, grant_id}, 32'd2);
    wait_done(n, ok);
    req = '0;
    check("to_done_seen", {31'd0, ok}, 32'd1);
    check("to_wait_cycles", n, TO);
    check("to_done_vec", {28'd0, done}, 32'b0100);
    check("to_rstatus", {30'd0, rstatus}, {30'd0, ST_TIMEOUT});
    check("to_rdata", {24'd0, rdata}, 32'd0);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_mem_en", {31'd0, mem_en}, 32'd0);
    @(negedge clk);
    check("to_idle", {31'd0, busy}, 32'd0);
    check("to_mem_reset", {31'd0, mem_reset}, 32'd0);
    check("to_err_sticky", {31'd0, err}, 32'd1);

    // Reset during WAIT: pointer is 3 here, so 3 wins first
    set_fields(1, 1'b0, 8'h08, 8'h00);
    set_fields(3, 1'b0, 8'h3C, 8'h00);
    req = 4'b1010;
    wait_en(ok);
    check("rw_grant_seen", {31'd0, ok}, 32'd1);
    check("rw_grant_pre", {30'd0, grant_id}, 32'd3);
    repeat (3) @(negedge clk);
    check("rw_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("rw_mem_en", {31'd0, mem_en}, 32'd0);
    check("rw_busy", {31'd0, busy}, 32'd0);
    check("rw_done", {28'd0, done}, 32'd0);
    check("rw_mem_reset", {31'd0, mem_reset}, 32'd0);
    check("rw_err_clr", {31'd0, err}, 32'd0);
    @(negedge clk);
    hang  = 1'b0;
    check("rw_no_done", {28'd0, done}, 32'd0);
    reset = 1'b1;
    wait_en(ok);
    check("rw_regrant_seen", {31'd0, ok}, 32'd1);
    check("rw_regrant", {30'd0, grant_id}, 32'd1);
    wait_done(n, ok);
    req = 4'b1000;
    check("rw_done1", {28'd0, done}, 32'b0010);
    check("rw_rdata1", {24'd0, rdata}, 32'hF0);
    wait_done(n, ok);
    req = '0;
    check("rw_done3", {28'd0, done}, 32'b1000);
    check("rw_rdata3", {24'd0, rdata}, 32'h5A);
    @(negedge clk);

    // Ready stuck high: completes at once, then RECOVER times out
    stuck = 1'b1;
    set_fields(0, 1'b0, 8'h01, 8'h00);
    req = 4'b0001;
    wait_en(ok);
    check("st_grant_seen", {31'd0, ok}, 32'd1);
    wait_done(n, ok);
    req = '0;
    check("st_done_seen", {31'd0, ok}, 32'd1);
    check("st_done_vec", {28'd0, done}, 32'b0001);
    check("st_rdata", {24'd0, rdata}, 32'h3C);
    check("st_rstatus", {30'd0, rstatus}, 32'd0);
    check("st_err_pre", {31'd0, err}, 32'd0);
    check("st_mem_reset", {31'd0, mem_reset}, 32'd1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0) break;
    end
    check("st_recover_cycles", n, TO);
    check("st_err", {31'd0, err}, 32'd1);
    check("st_mem_reset_off", {31'd0, mem_reset}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port `memory` block between NUM_REQ requesters.
- Arbitration is round-robin. Each requester gets one complete en/ready transaction at a time.
- The block sequences the memory handshake: drive en/op/addr/datain, wait for ready, capture dataout/status, then assert the memory's reset until ready drops.
- A watchdog bounds every wait, so a hung memory cannot stall the requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 8, memory address width.
- DATA_WIDTH, 8, memory data width.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT or RECOVER before abort.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_op  in  NUM_REQ  per-requester op (1 = write, 0 = read).
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata  out  DATA_WIDTH  read data of the last completed transaction.
- rstatus  out  2  status of the last completed transaction.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky timeout flag, cleared only by reset.
- mem_en  out  1  memory enable.
- mem_op  out  1  memory op.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_datain  out  DATA_WIDTH  memory write data.
- mem_reset  out  1  memory handshake reset, active-high.
- mem_dataout  in  DATA_WIDTH  memory read data.
- mem_status  in  2  memory status.
- mem_ready  in  1  memory ready.

Behaviour:
- Reset (reset=0, async): all outputs 0, state=IDLE, rr pointer=0, watchdog=0.
- The mem_* outputs are registered.
- IDLE:
  - Pick the first asserted req scanning upward from the pointer, modulo NUM_REQ.
  - On an edge with any req high: latch op/addr/wdata of the winner into mem_op/mem_addr/mem_datain, set mem_en=1, grant_id=winner, pointer=winner+1 (wraps NUM_REQ-1 -> 0), go WAIT.
  - No req: stay in IDLE, mem_en=0.
- WAIT:
  - mem_en held at 1 and mem_* held stable.
  - Watchdog increments each cycle.
  - On an edge with mem_ready=1: rdata<=mem_dataout, rstatus<=mem_status, done[grant_id]<=1 for one cycle, mem_en<=0, mem_reset<=1, watchdog<=0, go RECOVER.
  - On watchdog reaching TIMEOUT_CYCLES-1: rstatus<=2'b11, rdata<=0, done pulse, err<=1, mem_en<=0, mem_reset<=1, go RECOVER.
- RECOVER:
  - mem_reset held at 1.
  - On an edge with mem_ready=0: mem_reset<=0, go IDLE.
  - Watchdog expiry: err<=1, mem_reset<=0, go IDLE.
- Minimum occupancy per transaction is 3 cycles: IDLE->WAIT, WAIT->RECOVER, RECOVER->IDLE.
- A new grant can occur on the edge after RECOVER exits, so there is no back-to-back issue without passing through IDLE.
- rdata/rstatus update only on completion and hold until the next completion. For writes, rdata takes mem_dataout as-is.
- A requester dropping req mid-transaction does not abort it; done is still pulsed.
- A requester must hold req until it sees done. If req is still high after done, it re-requests but loses priority to the others.
- Simultaneous requests are served in strict rotation; no requester waits more than NUM_REQ-1 grants.
- Reset mid-transaction returns to IDLE with mem_en=0 and mem_reset=0 immediately, and no done pulse is issued.
- Status code 2'b11 is reserved for timeout. Other values pass through from mem_status.

Decomposition:
- Shared package `mem_pkg`:
  - state encodings IDLE=2'd0, WAIT=2'd1, RECOVER=2'd2;
  - ST_TIMEOUT=2'b11;
  - OP_READ=1'b0, OP_WRITE=1'b1.
- One combinational sub-module, `mem_rr_pick`:
  - inputs: req vector and pointer;
  - outputs: winner index and valid.
- The FSM and watchdog stay in mem_arbiter.

Test Plan:
- Bench memory model: ready 3 cycles after en; ready drops 1 cycle after mem_reset.
- Single write: req[0], op=1, addr=8'h08, wdata=8'hF0 -> mem_en high with mem_addr=8'h08, mem_datain=8'hF0; done[0] pulses once; rstatus=model status; mem_reset deasserts after ready falls.
- Read-back: req[1], op=0, addr=8'h08 -> done[1] pulses; rdata=8'hF0.
- Contention: req=4'b1111 held, each requester dropping its req on its done -> grant order 0,1,2,3. Then req[3] and req[0] -> 3 is served last after the pointer wraps to 0, so order is 0 then 3.
- Timeout: model never raises ready, TIMEOUT_CYCLES=8 -> done[grant] pulses at the 8th WAIT cycle; rstatus=2'b11; err=1; block returns to IDLE.
- Reset mid-WAIT: pull reset low during WAIT -> mem_en=0, busy=0, no done pulse. After release, the pending req is re-granted starting from pointer 0.
